// File: rtl/frame_sum_collector.sv
// frame_sum_collector: sums FRAME valid samples per frame into a DEPTH-entry FIFO.
// Optional macro FRAME_SUM_SAT_EN makes the frame accumulator saturate instead of wrap.
module frame_sum_collector #(
  parameter int W     = 8,
  parameter int FRAME = 4,
  parameter int DEPTH = 4,
  parameter int AW    = W + $clog2(FRAME)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int BW = $clog2(FRAME);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] wr_q, wr_d;
  logic [LW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];

  logic [AW-1:0] sum;
  logic [LW-1:0] fill;
  logic          last;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop;

`ifdef FRAME_SUM_SAT_EN
  logic [AW:0] wide;
  // Clamp at all-ones; a clamped acc stays clamped since samples are unsigned.
  always_comb begin
    wide = {1'b0, acc_q} + {1'b0, AW'(in_data)};
    sum  = wide[AW] ? '1 : wide[AW-1:0];
  end
`else
  // Plain modulo-2**AW accumulation.
  always_comb begin
    sum = acc_q + AW'(in_data);
  end
`endif

  // Occupancy, handshake and push/drop decisions.
  always_comb begin
    fill     = wr_q - rd_q;
    empty    = (fill == '0);
    full     = (fill == LW'(DEPTH));
    last     = (beat_q == BW'(FRAME - 1));
    pop      = ~empty & out_ready;
    push_req = in_valid & last;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Next-state for accumulator, beat counter, FIFO pointers and storage.
  always_comb begin
    acc_d  = acc_q;
    beat_d = beat_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    mem_d  = mem_q;
    if (clr) begin
      acc_d  = '0;
      beat_d = '0;
      wr_d   = '0;
      rd_d   = '0;
      ovf_d  = 1'b0;
    end else begin
      if (in_valid) begin
        if (last) begin
          acc_d  = '0;
          beat_d = '0;
        end else begin
          acc_d  = sum;
          beat_d = beat_q + BW'(1);
        end
      end
      if (pop) rd_d = rd_q + LW'(1);
      if (push) begin
        wr_d = wr_q + LW'(1);
        mem_d[wr_q[PW-1:0]] = sum;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      beat_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q  <= acc_d;
      beat_q <= beat_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      mem_q  <= mem_d;
    end
  end

  // Head entry is shown only while the FIFO holds data.
  always_comb begin
    out_valid = ~empty;
    out_data  = empty ? '0 : mem_q[rd_q[PW-1:0]];
    level     = fill;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_frame_sum_collector.sv
// tb_frame_sum_collector: table vectors, directed corner sequences and random
// stimulus against a queue-based model; also a narrow AW=9 instance.
module tb_frame_sum_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       out_valid;
  logic [9:0] out_data;
  logic [2:0] level;
  logic       overflow;

  logic       out_valid9;
  logic [8:0] out_data9;
  logic [2:0] level9;
  logic       overflow9;

  int total = 0;
  int bad   = 0;

  int q0[$];
  int q1[$];
  int acc0, acc1, cnt;
  bit ovf0, ovf1;

  always #5 clk = ~clk;

  frame_sum_collector u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow)
  );

  frame_sum_collector #(.AW(9)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid9), .out_ready(out_ready),
    .out_data(out_data9), .level(level9), .overflow(overflow9)
  );

  typedef struct {
    bit iv;
    int id;
    bit rdy;
    bit ev;
    int ed;
    int el;
  } vec_t;

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, got, want);
    end
  endtask

  function automatic int addm(input int a, input int b, input int aw);
    int s;
    int mx;
    s  = a + b;
    mx = (1 << aw) - 1;
`ifdef FRAME_SUM_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s % (mx + 1);
`endif
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    acc0 = 0;
    acc1 = 0;
    cnt  = 0;
    ovf0 = 0;
    ovf1 = 0;
  endtask

  task automatic model_step(input bit iv, input int id, input bit rdy, input bit c);
    bit full0, full1, pop0, pop1, fin;
    int s0, s1;
    if (c) begin
      model_clear();
      return;
    end
    full0 = (q0.size() == 4);
    full1 = (q1.size() == 4);
    pop0  = (q0.size() > 0) && rdy;
    pop1  = (q1.size() > 0) && rdy;
    fin   = iv && (cnt == 3);
    s0    = addm(acc0, id, 10);
    s1    = addm(acc1, id, 9);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (iv) begin
      if (fin) begin
        acc0 = 0;
        acc1 = 0;
        cnt  = 0;
        if (full0 && !pop0) ovf0 = 1; else q0.push_back(s0);
        if (full1 && !pop1) ovf1 = 1; else q1.push_back(s1);
      end else begin
        acc0 = s0;
        acc1 = s1;
        cnt++;
      end
    end
  endtask

  task automatic check_all();
    chk("m_valid", out_valid, q0.size() > 0);
    chk("m_data", out_data, q0.size() > 0 ? q0[0] : 0);
    chk("m_level", level, q0.size());
    chk("m_ovf", overflow, ovf0);
    chk("m_data9", out_data9, q1.size() > 0 ? q1[0] : 0);
    chk("m_ovf9", overflow9, ovf1);
  endtask

  task automatic step(input bit iv, input int id, input bit rdy, input bit c);
    in_valid  = iv;
    in_data   = id[7:0];
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    model_step(iv, id, rdy, c);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    chk("ar_valid", out_valid, 0);
    chk("ar_level", level, 0);
    chk("ar_data", out_data, 0);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[14];
  int pops;
  int lastv;
  int exp9;

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    tbl[0]  = '{1'b1, 10, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 20, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 30, 1'b1, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 40, 1'b1, 1'b1, 100, 1};
    tbl[4]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{1'b1, 10, 1'b1, 1'b0, 0, 0};
    tbl[6]  = '{1'b0, 99, 1'b1, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 20, 1'b1, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0};
    tbl[9]  = '{1'b1, 30, 1'b1, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 7, 1'b1, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 0, 1'b1, 1'b0, 0, 0};
    tbl[12] = '{1'b1, 40, 1'b1, 1'b1, 100, 1};
    tbl[13] = '{1'b0, 0, 1'b1, 1'b0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].el);
    end

    // Full FIFO with drop, then drain.
    for (int i = 0; i < 20; i++) step(1'b1, 1, 1'b0, 1'b0);
    chk("t3_level", level, 4);
    chk("t3_head", out_data, 4);
    chk("t3_ovf", overflow, 1);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        pops++;
        chk("t3_popval", out_data, 4);
      end
      step(1'b0, 0, 1'b1, 1'b0);
    end
    chk("t3_pops", pops, 4);
    chk("t3_ovf_after", overflow, 1);

    // Push and pop together while full.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) step(1'b1, k, 1'b0, 1'b0);
    chk("t4_full", level, 4);
    for (int j = 0; j < 3; j++) step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    chk("t4_level", level, 4);
    chk("t4_ovf", overflow, 0);
    pops = 0;
    lastv = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) begin
        pops++;
        lastv = out_data;
      end
      step(1'b0, 0, 1'b1, 1'b0);
    end
    chk("t4_pops", pops, 4);
    chk("t4_last", lastv, 20);

    // Narrow accumulator: wrap or saturate.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) step(1'b1, 200, 1'b0, 1'b0);
`ifdef FRAME_SUM_SAT_EN
    exp9 = 511;
`else
    exp9 = 288;
`endif
    chk("t5_narrow", out_data9, exp9);
    chk("t5_wide", out_data, 800);

    // Async reset mid-frame.
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 50, 1'b1, 1'b0);
    step(1'b1, 50, 1'b1, 1'b0);
    async_reset();
    for (int j = 0; j < 4; j++) step(1'b1, 5, 1'b0, 1'b0);
    chk("t6_rst_sum", out_data, 20);

    // Synchronous clear mid-frame, with overflow set beforehand.
    for (int i = 0; i < 16; i++) step(1'b1, 3, 1'b0, 1'b0);
    chk("t6_pre_ovf", overflow, 1);
    step(1'b1, 50, 1'b0, 1'b0);
    step(1'b1, 50, 1'b0, 1'b0);
    step(1'b1, 50, 1'b1, 1'b1);
    chk("t6_clr_level", level, 0);
    chk("t6_clr_ovf", overflow, 0);
    for (int j = 0; j < 4; j++) step(1'b1, 5, 1'b0, 1'b0);
    chk("t6_clr_sum", out_data, 20);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 255)),
           ($urandom % 3) == 0, ($urandom % 80) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
